warp_lsu: RTL

WARP_LSU -- requirements
Module: warp_lsu

---
 rtl/warp_lsu_pkg.sv | 36 +++
 rtl/warp_lsu_priority_encoder.sv | 31 +++
 rtl/warp_lsu.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/warp_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : warp_lsu_pkg
// Brief    : Shared types for the warp load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_lsu_pkg;

    localparam int unsigned c_DATA_WIDTH = `DATA_WIDTH;

    typedef logic [c_DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_DONE       = 2'd2
    } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/warp_lsu_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder
// Brief    : Returns the index of the lowest set bit of a request vector.
// Revision : 1.0 - initial release
// ============================================================================

module priority_encoder #(
    parameter int WIDTH       = 32,
    parameter int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]       request,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (request[i]) begin
                index = INDEX_WIDTH'(i);
            end
        end
    end

    assign valid = |request;

endmodule

`default_nettype wire

// File: rtl/warp_lsu.sv
`default_nettype none
// ============================================================================
// Module   : warp_lsu
// Brief    : Per-warp load/store unit; serialises masked threads onto one
//            read port and one write port, lowest thread first.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

import warp_lsu_pkg::*;

module warp_lsu #(
    parameter int THREADS_PER_WARP = 32,
    parameter int DATA_WIDTH       = `DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [THREADS_PER_WARP-1:0] thread_enable,
    input  warp_state_t                 warp_state,
    input  logic                        decoded_mem_read_enable,
    input  logic                        decoded_mem_write_enable,
    input  data_t                       decoded_immediate,
    input  data_t                       rs1 [THREADS_PER_WARP],
    input  data_t                       rs2 [THREADS_PER_WARP],
    output logic                        mem_read_valid,
    output data_t                       mem_read_address,
    input  logic                        mem_read_ready,
    input  data_t                       mem_read_data,
    output logic                        mem_write_valid,
    output data_t                       mem_write_address,
    output data_t                       mem_write_data,
    input  logic                        mem_write_ready,
    output data_t                       lsu_out [THREADS_PER_WARP],
    output lsu_state_t                  lsu_state
);

    localparam int c_IDX_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

    lsu_state_t                  r_state;
    logic [THREADS_PER_WARP-1:0] r_pending;
    logic [c_IDX_W-1:0]          r_cur;
    logic                        r_is_load;

    logic [THREADS_PER_WARP-1:0] w_remaining;
    logic [THREADS_PER_WARP-1:0] w_enc_in;
    logic [c_IDX_W-1:0]          w_idx;
    logic                        w_enc_valid;
    logic                        w_start;
    logic                        w_fire;
    logic                        w_issue;
    logic                        w_issue_load;
    logic [DATA_WIDTH-1:0]       w_sum;
    data_t                       w_addr;

    always_comb begin
        w_remaining        = r_pending;
        w_remaining[r_cur] = 1'b0;
    end

    // In IDLE the encoder looks at the live mask so the first request can be
    // registered on the same edge that takes the snapshot.
    assign w_enc_in = (r_state == LSU_IDLE) ? thread_enable : w_remaining;

    priority_encoder #(
        .WIDTH       (THREADS_PER_WARP),
        .INDEX_WIDTH (c_IDX_W)
    ) u_thread_select (
        .request (w_enc_in),
        .index   (w_idx),
        .valid   (w_enc_valid)
    );

    assign w_start = (r_state == LSU_IDLE) && (warp_state == WARP_WAIT) &&
                     (decoded_mem_read_enable || decoded_mem_write_enable);

    assign w_fire  = (r_state == LSU_REQUESTING) &&
                     (r_is_load ? (mem_read_valid && mem_read_ready)
                                : (mem_write_valid && mem_write_ready));

    assign w_issue      = (w_start || w_fire) && w_enc_valid;
    // A request with both selects set is a load.
    assign w_issue_load = (r_state == LSU_IDLE) ? decoded_mem_read_enable : r_is_load;

    assign w_sum  = DATA_WIDTH'(rs1[w_idx]) + DATA_WIDTH'(decoded_immediate);
    assign w_addr = data_t'(w_sum);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= LSU_IDLE;
            r_pending         <= '0;
            r_cur             <= '0;
            r_is_load         <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            for (int i = 0; i < THREADS_PER_WARP; i++) begin
                lsu_out[i] <= '0;
            end
        end else if (enable) begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_start) begin
                        r_pending <= thread_enable;
                        r_is_load <= decoded_mem_read_enable;
                        r_state   <= w_enc_valid ? LSU_REQUESTING : LSU_DONE;
                    end
                end
                LSU_REQUESTING: begin
                    if (w_fire) begin
                        if (r_is_load) begin
                            lsu_out[r_cur] <= mem_read_data;
                        end
                        r_pending <= w_remaining;
                        if (!w_enc_valid) begin
                            mem_read_valid  <= 1'b0;
                            mem_write_valid <= 1'b0;
                            r_state         <= LSU_DONE;
                        end
                    end
                end
                LSU_DONE: begin
                    if (warp_state == WARP_UPDATE) begin
                        r_state <= LSU_IDLE;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase

            if (w_issue) begin
                r_cur           <= w_idx;
                mem_read_valid  <= w_issue_load;
                mem_write_valid <= !w_issue_load;
                if (w_issue_load) begin
                    mem_read_address <= w_addr;
                end else begin
                    mem_write_address <= w_addr;
                    mem_write_data    <= rs2[w_idx];
                end
            end
        end
    end

    assign lsu_state = r_state;

endmodule

`default_nettype wire
